// File: rtl/tick_timer.sv
// Tick-driven programmable down-timer with one-shot and periodic modes.
// Optional expiry counter output exp_cnt when TICK_TIMER_EXP_CNT_EN is defined.
module tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick_in,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         expire_tick,
`ifdef TICK_TIMER_EXP_CNT_EN
  output logic [7:0]   exp_cnt,
`endif
  output logic [W-1:0] count
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t       state_r;
  logic [W-1:0] load_r;
  logic         mode_r;
  logic [W-1:0] count_r;
  logic         busy_r;
  logic         expire_r;
`ifdef TICK_TIMER_EXP_CNT_EN
  logic [7:0]   exp_cnt_r;
`endif

  // Timer FSM: stop beats start, start beats tick; expiry strobe lasts one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      load_r   <= {W{1'b0}};
      mode_r   <= 1'b0;
      count_r  <= {W{1'b0}};
      busy_r   <= 1'b0;
      expire_r <= 1'b0;
`ifdef TICK_TIMER_EXP_CNT_EN
      exp_cnt_r <= 8'd0;
`endif
    end else begin
      expire_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (start) begin
            load_r  <= load_val;
            mode_r  <= periodic;
            count_r <= load_val;
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
`ifdef TICK_TIMER_EXP_CNT_EN
            exp_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            count_r <= {W{1'b0}};
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (start) begin
            load_r  <= load_val;
            mode_r  <= periodic;
            count_r <= load_val;
            busy_r  <= 1'b1;
`ifdef TICK_TIMER_EXP_CNT_EN
            exp_cnt_r <= 8'd0;
`endif
          end else if (tick_in) begin
            if (count_r != {W{1'b0}}) begin
              count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
            end else begin
              expire_r <= 1'b1;
`ifdef TICK_TIMER_EXP_CNT_EN
              if (exp_cnt_r != 8'd255) begin
                exp_cnt_r <= exp_cnt_r + 8'd1;
              end else begin
                exp_cnt_r <= exp_cnt_r;
              end
`endif
              // Periodic reload keeps running; one-shot parks at zero in IDLE.
              if (mode_r) begin
                count_r <= load_r;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= {W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign expire_tick = expire_r;
  assign count       = count_r;
`ifdef TICK_TIMER_EXP_CNT_EN
  assign exp_cnt     = exp_cnt_r;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Randomized and directed bench for tick_timer against a remaining-ticks model.
module tb_tick_timer;
  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         tick_in;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] load_val;
  logic         busy;
  logic         expire_tick;
  logic [W-1:0] count;
`ifdef TICK_TIMER_EXP_CNT_EN
  logic [7:0]   exp_cnt;
`endif

  int total;
  int bad;
  bit chk_en;

  // Model state: ticks still needed until expiry, rather than a raw counter.
  bit m_run;
  int m_rem;
  int m_reload;
  bit m_per;
  bit m_exp;
  int m_ecnt;

  tick_timer #(.W(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick_in(tick_in),
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .load_val(load_val),
    .busy(busy),
    .expire_tick(expire_tick),
`ifdef TICK_TIMER_EXP_CNT_EN
    .exp_cnt(exp_cnt),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    return m_run ? (m_rem - 1) : 0;
  endfunction

  // Reference model advanced on each clock edge or asynchronous reset.
  initial begin
    m_run = 0; m_rem = 1; m_reload = 0; m_per = 0; m_exp = 0; m_ecnt = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_run = 0; m_rem = 1; m_reload = 0; m_per = 0; m_exp = 0; m_ecnt = 0;
      end else begin
        m_exp = 0;
        if (stop) begin
          m_run = 0;
        end else if (start) begin
          m_run = 1; m_rem = int'(load_val) + 1; m_reload = int'(load_val);
          m_per = periodic; m_ecnt = 0;
        end else if (m_run && tick_in) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_exp = 1;
            if (m_ecnt < 255) m_ecnt = m_ecnt + 1;
            if (m_per) m_rem = m_reload + 1;
            else m_run = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", int'(busy), int'(m_run));
        check("expire_tick", int'(expire_tick), int'(m_exp));
        check("count", int'(count), model_count());
`ifdef TICK_TIMER_EXP_CNT_EN
        check("exp_cnt", int'(exp_cnt), m_ecnt);
`endif
      end
    end
  end

  task automatic drive(input bit t, input bit s, input bit p, input bit sp, input int lv);
    tick_in = t; start = s; periodic = p; stop = sp; load_val = W'(lv);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 0;
    reset_n = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0;
    periodic = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);
    check("reset_expire", int'(expire_tick), 0);
    reset_n = 1'b1;
    chk_en = 1;

    // One-shot, load 3, tick every 4 clocks.
    drive(0, 1, 0, 0, 3);
    check("t1_start_count", int'(count), 3);
    for (int k = 1; k <= 4; k++) begin
      idle(3);
      drive(1, 0, 0, 0, 0);
      if (k < 4) check("t1_count", int'(count), 3 - k);
    end
    check("t1_expire", int'(expire_tick), 1);
    check("t1_busy_fall", int'(busy), 0);
    check("t1_count_end", int'(count), 0);
    idle(1);
    check("t1_expire_once", int'(expire_tick), 0);

    // Periodic, load 2, nine ticks.
    drive(0, 1, 1, 0, 2);
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 0, 0);
      if (k % 3 == 0) begin
        check("t2_expire", int'(expire_tick), 1);
        check("t2_reload", int'(count), 2);
        check("t2_busy", int'(busy), 1);
      end
      idle(1);
    end

    // Periodic, load 0, back-to-back ticks.
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0);
      check("t3_b2b_expire", int'(expire_tick), 1);
    end
`ifdef TICK_TIMER_EXP_CNT_EN
    check("t3_exp_cnt", int'(exp_cnt), 4);
`endif
    idle(1);
    check("t3_expire_end", int'(expire_tick), 0);

    // Stop with tick at count 5, then start+stop+tick in IDLE.
    drive(0, 1, 0, 0, 9);
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 0);
    check("t4_count5", int'(count), 5);
    drive(1, 0, 0, 1, 0);
    check("t4_stop_busy", int'(busy), 0);
    check("t4_stop_count", int'(count), 0);
    check("t4_stop_noexp", int'(expire_tick), 0);
    drive(1, 1, 0, 1, 3);
    check("t4_idle_stop_wins", int'(busy), 0);

    // Restart with tick at count 1.
    drive(0, 1, 0, 0, 4);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0);
    check("t5_count1", int'(count), 1);
    drive(1, 1, 0, 0, 7);
    check("t5_restart_count", int'(count), 7);
    check("t5_restart_busy", int'(busy), 1);
    for (int k = 0; k < 7; k++) drive(1, 0, 0, 0, 0);
    check("t5_no_early_exp", int'(expire_tick), 0);
    drive(1, 0, 0, 0, 0);
    check("t5_expire", int'(expire_tick), 1);

    // Maximum load value needs 2^W ticks.
    drive(0, 1, 0, 0, (1 << W) - 1);
    for (int k = 0; k < (1 << W) - 1; k++) drive(1, 0, 0, 0, 0);
    check("max_count0", int'(count), 0);
    check("max_no_exp", int'(expire_tick), 0);
    drive(1, 0, 0, 0, 0);
    check("max_expire", int'(expire_tick), 1);

    // Asynchronous reset mid-cycle during a periodic run.
    drive(0, 1, 1, 0, 3);
    drive(1, 0, 0, 0, 0);
    check("t6_count2", int'(count), 2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_expire", int'(expire_tick), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 0);
    check("t6_no_run", int'(busy), 0);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)));
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
Programmable tick-driven down-timer that sits directly downstream of the free-running binary counter and consumes its one-cycle max_tick pulse as its time base. The timer supports one-shot and periodic operation. It produces a one-cycle expire_tick strobe for downstream FSMs, for example an LED blinker or a debounce sampler. It also exposes its live count for status readback.

Parameters:
W, 16, width of the load value and the internal down-counter.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
reset_n  input  1  asynchronous active-low reset.
tick_in  input  1  time-base pulse, one clk wide (the upstream counter's max_tick).
start  input  1  one-cycle command: latch load_val and periodic, then begin or restart timing.
stop  input  1  one-cycle command: abort timing and return to idle.
periodic  input  1  mode, sampled only on start. 1 = auto-reload, 0 = one-shot.
load_val  input  W  terminal count, sampled only on start. Period is load_val+1 ticks.
busy  output  1  high while in RUN.
expire_tick  output  1  registered one-cycle strobe when the count expires.
count  output  W  current down-counter value.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, count=0, expire_tick=0, busy=0, load_reg=0, mode_reg=0.
- State machine has two states, IDLE and RUN. busy equals (state==RUN) and is registered.
- IDLE:
  - start=1: load_reg<=load_val, mode_reg<=periodic, count<=load_val, next state RUN.
  - tick_in is ignored in IDLE.
- RUN, evaluated in this priority order each cycle:
  1. stop=1: count<=0, next state IDLE, no expire_tick. stop beats start and tick_in in the same cycle.
  2. start=1: reload load_reg, mode_reg and count from the inputs exactly as in IDLE; stay in RUN. A tick_in in the same cycle is discarded.
  3. tick_in=1 and count!=0: count<=count-1.
  4. tick_in=1 and count==0: expire_tick<=1 for exactly the next cycle.
     - mode_reg=1: count<=load_reg, stay in RUN.
     - mode_reg=0: count stays 0, next state IDLE.
- Latency: expire_tick is high in the cycle immediately after the cycle in which tick_in was sampled with count==0. Tick-to-expire latency is 1 clk.
- Period: from the start cycle, the (load_val+1)th tick_in causes expiry.
  - load_val=0 expires on the first tick.
  - load_val=2^W-1 needs 2^W ticks. No overflow is possible; the counter only decrements and never wraps below 0.
- stop in IDLE: no effect. start and stop together in IDLE: stop wins, remain in IDLE.
- Back-to-back ticks on consecutive cycles are legal. Each tick decrements exactly once, so periodic expiry strobes can occur on consecutive cycles when load_val=0.
- Changes to load_val or periodic during RUN have no effect until the next start.
- Asserting reset_n=0 mid-run immediately returns every register to its reset value. Any expire_tick in flight is dropped.

Optional Feature:
Macro TICK_TIMER_EXP_CNT_EN.
- Defined:
  - Adds output port exp_cnt, 8 bits, reset value 0.
  - Increments on every cycle in which expire_tick is set and saturates at 255.
  - Cleared to 0 on every accepted start, including a restart in RUN.
  - If a start and an expiry would coincide, start takes priority per the rules above, so there is no expiry.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then start with load_val=3, periodic=0, then tick_in every 4 clks -> count goes 3,2,1,0. expire_tick is high exactly 1 clk after the 4th tick. busy falls in that same cycle and count=0.
2. start with load_val=2, periodic=1, then 9 ticks -> expire_tick pulses after ticks 3, 6 and 9. busy stays 1 and count reloads to 2 after each expiry.
3. start with load_val=0, periodic=1, tick_in held high for 4 consecutive clks -> expire_tick is high for the 4 clks each following a tick, back to back. With the macro, exp_cnt=4.
4. Running with count=5, assert stop and tick_in in the same cycle -> next cycle state=IDLE, count=0, busy=0, no expire_tick. Then start, stop and tick_in together in IDLE -> remains IDLE.
5. Running with load_val=4 and count=1, assert start with load_val=7 plus tick_in -> count=7, tick discarded, stays in RUN. The next expiry comes after 8 more ticks.
6. Periodic run at count=2, drive reset_n low for 1 clk asynchronously, mid-cycle -> outputs immediately 0. Subsequent ticks cause no expiry until a new start.
